// File: rtl/multiplicador_seq_if.sv
// Request/response bundle for the sequential Booth multiplier.
//   start, signed_mode, cancel, multiplicand, multiplier : requester -> multiplier
//   out_high, out_low, busy, done                        : multiplier -> requester
// master = requester side, slave = multiplier side.
interface multiplicador_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_mode;
  logic             cancel;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic [WIDTH-1:0] out_high;
  logic [WIDTH-1:0] out_low;
  logic             busy;
  logic             done;

  modport master (
    output start, signed_mode, cancel, multiplicand, multiplier,
    input  out_high, out_low, busy, done
  );

  modport slave (
    input  start, signed_mode, cancel, multiplicand, multiplier,
    output out_high, out_low, busy, done
  );
endinterface

// File: rtl/multiplicador_seq.sv
// Sequential radix-2 Booth multiplier (MULT/MULTU path).
// Operands are extended to WIDTH+1 bits (sign or zero by signed_mode) and
// WIDTH+1 Booth steps are run, one per clock, so a single signed datapath
// handles both modes. Result lands in out_high/out_low with a 1-cycle done.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : multiplicador_seq_if.slave (start/cancel/operands in,
//           out_high/out_low/busy/done out)
module multiplicador_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic                clk,
  input  logic                reset,
  multiplicador_seq_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [WIDTH:0]   acc, q, m;
  logic             q_1;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] out_high, out_low;
  logic             done;

  logic             load, step, finish;
  logic [WIDTH:0]   a_add;
  // {sign, A, Q}: the arithmetic right shift of {A, Q, Q_1}, Q_1 dropping off
  logic [2*WIDTH+2:0] shr;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        load     = 1'b1;
        state_nx = RUN;
      end
      RUN: begin
        // cancel beats the final iteration: no step, no result write
        if (bus.cancel) begin
          state_nx = IDLE;
        end else begin
          step = 1'b1;
          if (cnt == CNT_W'(WIDTH)) begin
            finish   = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---------------------------------------------------------- Booth step
  always_comb begin
    case ({q[0], q_1})
      2'b01:   a_add = acc + m;
      2'b10:   a_add = acc - m;
      default: a_add = acc;
    endcase
  end

  assign shr = {a_add[WIDTH], a_add, q};

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      q        <= '0;
      q_1      <= 1'b0;
      m        <= '0;
      cnt      <= '0;
      out_high <= '0;
      out_low  <= '0;
      done     <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        acc <= '0;
        q   <= {bus.signed_mode & bus.multiplier[WIDTH-1],   bus.multiplier};
        m   <= {bus.signed_mode & bus.multiplicand[WIDTH-1], bus.multiplicand};
        q_1 <= 1'b0;
        cnt <= '0;
      end else if (step) begin
        acc <= shr[2*WIDTH+2:WIDTH+2];
        q   <= shr[WIDTH+1:1];
        q_1 <= shr[0];
        cnt <= cnt + CNT_W'(1);
      end
      // low 2*WIDTH bits of the shifted {A, Q}
      if (finish) begin
        out_high <= shr[2*WIDTH:WIDTH+1];
        out_low  <= shr[WIDTH:1];
      end
    end
  end

  assign bus.out_high = out_high;
  assign bus.out_low  = out_low;
  assign bus.done     = done;
  assign bus.busy     = (state == RUN);

endmodule

// File: tb/tb_multiplicador_seq.sv
// Directed bench for multiplicador_seq: a WIDTH=32 and a WIDTH=8 instance,
// inputs driven and outputs sampled on the falling clock edge.
module tb_multiplicador_seq;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  multiplicador_seq_if #(.WIDTH(32)) bus32();
  multiplicador_seq_if #(.WIDTH(8))  bus8();

  multiplicador_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  multiplicador_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a start for one edge (E0); returns at the falling edge after E0.
  task automatic go32(input logic sm, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus32.start = 1'b1; bus32.signed_mode = sm;
    bus32.multiplicand = a; bus32.multiplier = b;
    @(negedge clk);
    bus32.start = 1'b0;
    chk("busy_after_start", {63'd0, bus32.busy}, 64'd1);
  endtask

  // From the falling edge after E<n_now>, run to E33 and check the result.
  task automatic fin32(input string tag, input int n_now, input logic [63:0] exp);
    repeat (32 - n_now) @(negedge clk);
    chk({tag, "_busy_e32"}, {62'd0, bus32.busy, bus32.done}, 64'd2);
    @(negedge clk);
    chk({tag, "_done_e33"}, {62'd0, bus32.busy, bus32.done}, 64'd1);
    chk({tag, "_product"}, {bus32.out_high, bus32.out_low}, exp);
    @(negedge clk);
    chk({tag, "_done_drop"}, {63'd0, bus32.done}, 64'd0);
  endtask

  initial begin
    logic saw_done;
    bus32.start = 0; bus32.signed_mode = 0; bus32.cancel = 0;
    bus32.multiplicand = '0; bus32.multiplier = '0;
    bus8.start = 0; bus8.signed_mode = 0; bus8.cancel = 0;
    bus8.multiplicand = '0; bus8.multiplier = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst32_out", {bus32.out_high, bus32.out_low}, 64'd0);
    chk("rst32_flags", {62'd0, bus32.busy, bus32.done}, 64'd0);
    chk("rst8_all", {46'd0, bus8.out_high, bus8.out_low, bus8.busy, bus8.done}, 64'd0);
    reset = 1'b1;

    // signed 7 * -3 = -21
    go32(1'b1, 32'd7, 32'hFFFF_FFFD);
    fin32("s7xm3", 0, 64'hFFFF_FFFF_FFFF_FFEB);

    // unsigned max * max
    go32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    fin32("umax", 0, 64'hFFFF_FFFE_0000_0001);

    // signed min * min
    go32(1'b1, 32'h8000_0000, 32'h8000_0000);
    fin32("smin", 0, 64'h4000_0000_0000_0000);

    // restart at E10 with other operands/mode is ignored; 3*4 delivered at E33
    go32(1'b0, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    bus32.start = 1'b1; bus32.signed_mode = 1'b1;
    bus32.multiplicand = 32'd9; bus32.multiplier = 32'hFFFF_FFF0;
    @(negedge clk);
    bus32.start = 1'b0;
    chk("restart_busy", {62'd0, bus32.busy, bus32.done}, 64'd2);
    fin32("restart", 10, 64'd12);

    // cancel sampled at E20: idle next cycle, no done, previous result kept
    go32(1'b0, 32'd5, 32'd5);
    repeat (19) @(negedge clk);
    bus32.cancel = 1'b1;
    @(negedge clk);
    bus32.cancel = 1'b0;
    chk("cancel_flags", {62'd0, bus32.busy, bus32.done}, 64'd0);
    chk("cancel_keep", {bus32.out_high, bus32.out_low}, 64'd12);
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      saw_done |= bus32.done;
    end
    chk("cancel_no_done", {63'd0, saw_done}, 64'd0);
    go32(1'b1, 32'd6, 32'hFFFF_FFF9);
    fin32("after_cancel", 0, 64'hFFFF_FFFF_FFFF_FFD6);

    // reset asserted after E15: everything clears at once
    go32(1'b0, 32'd11, 32'd13);
    repeat (15) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_out", {bus32.out_high, bus32.out_low}, 64'd0);
    chk("midrst_flags", {62'd0, bus32.busy, bus32.done}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    go32(1'b0, 32'd5, 32'd6);
    fin32("post_rst", 0, 64'd30);

    // WIDTH=8: signed 0x80*0xFF, then unsigned same operands back-to-back
    @(negedge clk);
    bus8.start = 1'b1; bus8.signed_mode = 1'b1;
    bus8.multiplicand = 8'h80; bus8.multiplier = 8'hFF;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("w8s_busy_e8", {62'd0, bus8.busy, bus8.done}, 64'd2);
    @(negedge clk);
    chk("w8s_done_e9", {62'd0, bus8.busy, bus8.done}, 64'd1);
    chk("w8s_product", {48'd0, bus8.out_high, bus8.out_low}, 64'h0080);
    bus8.start = 1'b1; bus8.signed_mode = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    chk("w8u_b2b_start", {62'd0, bus8.busy, bus8.done}, 64'd2);
    chk("w8u_hold", {48'd0, bus8.out_high, bus8.out_low}, 64'h0080);
    repeat (8) @(negedge clk);
    chk("w8u_busy_e8", {62'd0, bus8.busy, bus8.done}, 64'd2);
    @(negedge clk);
    chk("w8u_done_e9", {62'd0, bus8.busy, bus8.done}, 64'd1);
    chk("w8u_product", {48'd0, bus8.out_high, bus8.out_low}, 64'h7F80);
    @(negedge clk);
    chk("w8u_done_drop", {63'd0, bus8.done}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
